// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg : shared types and the round-robin pick function for slave_rr_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_IDX_W   = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit of req at or above ptr, wrapping within n requesters.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_IDX_W-1:0]   ptr,
        input int                     n
    );
        logic [MAX_IDX_W-1:0] win;
        logic                 found;
        int                   idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (i < n) && req[idx[MAX_IDX_W-1:0]]) begin
                win   = idx[MAX_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_id_fifo.sv
// ============================================================================
// arb_id_fifo : in-order queue of master indices for outstanding reads
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_id_fifo #(
    parameter int WIDTH     = 2,
    parameter int DEPTH_EXP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             put,
    input  logic [WIDTH-1:0] din,
    input  logic             get,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_EXP;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_EXP-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_EXP-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_EXP:0]   count_q, count_d;
    logic                 do_put, do_get;

    assign full  = (count_q == (DEPTH_EXP+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A put into a full queue is accepted only when a get frees a slot on the same edge.
    always_comb begin
        do_get   = get & ~empty;
        do_put   = put & (~full | do_get);
        wr_ptr_d = do_put ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_get ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_put && !do_get) begin
            count_d = count_q + 1'b1;
        end else if (do_get && !do_put) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_put) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/slave_rr_arbiter.sv
// ============================================================================
// slave_rr_arbiter : round-robin sharing of one slave, read responses routed in order
// Optional grant watchdog with m_err port: define ARB_WDOG_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module slave_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_MASTERS          = 4,
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 32,
    parameter int RD_OUTSTANDING_EXP = 2,
    parameter int WDOG_CYCLES        = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS-1:0]            m_cmd,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [N_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [N_MASTERS-1:0]            m_resp,
    output logic                            s_req,
    output logic                            s_cmd,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    input  logic                            s_ack,
    input  logic [DATA_WIDTH-1:0]           s_rdata,
    input  logic                            s_resp
`ifdef ARB_WDOG_EN
   ,output logic [N_MASTERS-1:0]            m_err
`endif
);

    localparam int               IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    arb_state_t                  state_q, state_d;
    logic [IDX_W-1:0]            grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                        s_req_q, s_req_d;
    logic                        s_cmd_q, s_cmd_d;
    logic [ADDR_WIDTH-1:0]       s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]       s_wdata_q, s_wdata_d;
    logic [N_MASTERS-1:0]        m_ack_q, m_ack_d;
    logic [N_MASTERS-1:0]        m_resp_q, m_resp_d;
    logic [DATA_WIDTH-1:0]       m_rdata_q, m_rdata_d;

    logic [N_MASTERS-1:0]        elig;
    logic [MAX_MASTERS-1:0]      pick_req;
    logic [IDX_W-1:0]            winner;
    logic [IDX_W-1:0]            next_ptr;
    logic                        fifo_put, fifo_get, fifo_full, fifo_empty;
    logic [IDX_W-1:0]            fifo_dout;

`ifdef ARB_WDOG_EN
    localparam int               WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0]           wdog_cnt_q, wdog_cnt_d;
    logic [N_MASTERS-1:0]        m_err_q, m_err_d;
    assign m_err = m_err_q;
`else
    logic                        unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
`endif

    assign m_ack   = m_ack_q;
    assign m_resp  = m_resp_q;
    assign m_rdata = m_rdata_q;
    assign s_req   = s_req_q;
    assign s_cmd   = s_cmd_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;

    arb_id_fifo #(
        .WIDTH     (IDX_W),
        .DEPTH_EXP (RD_OUTSTANDING_EXP)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .put   (fifo_put),
        .din   (grant_idx_q),
        .get   (fifo_get),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        // Reads are held off while the ID queue cannot take another entry.
        elig     = '0;
        pick_req = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            elig[i]     = m_req[i] & (m_cmd[i] | ~fifo_full);
            pick_req[i] = elig[i];
        end
        winner   = IDX_W'(rr_pick(pick_req, MAX_IDX_W'(rr_ptr_q), N_MASTERS));
        next_ptr = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        s_req_d     = s_req_q;
        s_cmd_d     = s_cmd_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        m_ack_d     = '0;
        m_resp_d    = '0;
        m_rdata_d   = m_rdata_q;
        fifo_put    = 1'b0;
        fifo_get    = s_resp & ~fifo_empty;
`ifdef ARB_WDOG_EN
        wdog_cnt_d  = wdog_cnt_q;
        m_err_d     = '0;
`endif

        if (fifo_get) begin
            m_resp_d[fifo_dout] = 1'b1;
            m_rdata_d           = s_rdata;
        end

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d     = GRANT;
                    grant_idx_d = winner;
                    s_req_d     = 1'b1;
                    s_cmd_d     = m_cmd[winner];
                    s_addr_d    = m_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    s_wdata_d   = m_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_WDOG_EN
                    wdog_cnt_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (s_ack) begin
                    s_req_d              = 1'b0;
                    m_ack_d[grant_idx_q] = 1'b1;
                    fifo_put             = ~s_cmd_q;
                    rr_ptr_d             = next_ptr;
                    state_d              = IDLE;
                end
`ifdef ARB_WDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    s_req_d              = 1'b0;
                    m_err_d[grant_idx_q] = 1'b1;
                    rr_ptr_d             = next_ptr;
                    state_d              = IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            s_req_q     <= 1'b0;
            s_cmd_q     <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            m_ack_q     <= '0;
            m_resp_q    <= '0;
            m_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            s_req_q     <= s_req_d;
            s_cmd_q     <= s_cmd_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            m_ack_q     <= m_ack_d;
            m_resp_q    <= m_resp_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

`ifdef ARB_WDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            m_err_q    <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            m_err_q    <= m_err_d;
        end
    end
`endif

endmodule

`default_nettype wire
